// File: rtl/uart_tx.sv
// uart_tx: tick-aligned UART serializer, LSB-first, with optional parity and 1/2 stop bits.
// A word accepted in IDLE waits in ARMED so the start bit always begins on a fresh tick.
module uart_tx #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);
  typedef enum logic [2:0] {IDLE, ARMED, START, DATA, PAR, STOP} state_e;
  localparam int CW = $clog2(DATA_BITS);
  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 stop_q, stop_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      stop_q  <= 1'b0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      stop_q  <= stop_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    stop_d  = stop_q;
    par_d   = par_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (tx_valid) begin
        state_d = ARMED;
        shift_d = tx_data;
        par_d   = (PARITY == 1) ? ~^tx_data : ^tx_data;
      end
    end else if (baud_tick) begin
      case (state_q)
        ARMED: begin
          state_d = START;
          tx_d    = 1'b0;
        end
        START: begin
          state_d = DATA;
          tx_d    = shift_q[0];
          cnt_d   = '0;
        end
        DATA: begin
          if (cnt_q == CW'(DATA_BITS - 1)) begin
            state_d = (PARITY != 0) ? PAR : STOP;
            tx_d    = (PARITY != 0) ? par_q : 1'b1;
            stop_d  = 1'b0;
          end else begin
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
            cnt_d   = cnt_q + 1'b1;
          end
        end
        PAR: begin
          state_d = STOP;
          tx_d    = 1'b1;
          stop_d  = 1'b0;
        end
        STOP: begin
          if (STOP_BITS == 2 && !stop_q) stop_d = 1'b1;
          else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  assign tx       = tx_q;
  assign tx_done  = done_q;
  assign tx_ready = (state_q == IDLE);
  assign tx_busy  = (state_q != IDLE);
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: checks four uart_tx configurations (8N1, 8O1, 8E1, 8N2) cycle by cycle
// against a queue-of-bits line model driven by a 16-clk tick.
module tb_uart_tx;
  logic       clk, reset, baud_tick;
  logic [7:0] tx_data;
  logic [3:0] tx_valid;
  logic       tx_a[4], rdy_a[4], busy_a[4], done_a[4];
  int         passes = 0, total = 0, ph = 0;
  int         par_k[4] = '{0, 1, 2, 0};
  int         sb_k[4]  = '{1, 1, 1, 2};
  logic [7:0] src[$];
  logic       exp_q[$];
  logic       m_idle, m_tx, m_done;

  uart_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (.clk(clk), .reset(reset), .baud_tick(baud_tick),
    .tx_data(tx_data), .tx_valid(tx_valid[0]), .tx_ready(rdy_a[0]), .tx(tx_a[0]), .tx_busy(busy_a[0]), .tx_done(done_a[0]));
  uart_tx #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u1 (.clk(clk), .reset(reset), .baud_tick(baud_tick),
    .tx_data(tx_data), .tx_valid(tx_valid[1]), .tx_ready(rdy_a[1]), .tx(tx_a[1]), .tx_busy(busy_a[1]), .tx_done(done_a[1]));
  uart_tx #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u2 (.clk(clk), .reset(reset), .baud_tick(baud_tick),
    .tx_data(tx_data), .tx_valid(tx_valid[2]), .tx_ready(rdy_a[2]), .tx(tx_a[2]), .tx_busy(busy_a[2]), .tx_done(done_a[2]));
  uart_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u3 (.clk(clk), .reset(reset), .baud_tick(baud_tick),
    .tx_data(tx_data), .tx_valid(tx_valid[3]), .tx_ready(rdy_a[3]), .tx(tx_a[3]), .tx_busy(busy_a[3]), .tx_done(done_a[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drives instance k from src (valid held while words remain) with a tick every 16 clks,
  // comparing all outputs every cycle against the line model. Called and returns at a negedge.
  task automatic run(input int k, input int min_c, input int abort_t);
    int c = 0, t = 0;
    logic acc;
    logic [7:0] d;
    m_idle = 1'b1; m_tx = 1'b1; m_done = 1'b0;
    exp_q.delete();
    forever begin
      baud_tick = (ph == 15);
      ph = (ph + 1) % 16;
      tx_valid = '0;
      if (src.size() != 0) begin
        tx_valid[k] = 1'b1;
        tx_data = src[0];
      end else tx_data = 8'($urandom);
      @(posedge clk);
      acc = tx_valid[k] && m_idle;
      m_done = 1'b0;
      if (baud_tick && !m_idle) begin
        if (exp_q.size() != 0) m_tx = exp_q.pop_front();
        else begin
          m_tx = 1'b1; m_done = 1'b1; m_idle = 1'b1;
        end
      end
      if (acc) begin
        d = src.pop_front();
        m_idle = 1'b0;
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        if (par_k[k] != 0) exp_q.push_back(par_k[k] == 2 ? ^d : ~^d);
        for (int i = 0; i < sb_k[k]; i++) exp_q.push_back(1'b1);
      end
      if (baud_tick) t++;
      @(negedge clk);
      c++;
      total += 4;
      if (tx_a[k] !== m_tx) $display("FAIL tx u%0d cyc %0d: got %b want %b", k, c, tx_a[k], m_tx);
      else passes++;
      if (done_a[k] !== m_done) $display("FAIL done u%0d cyc %0d: got %b want %b", k, c, done_a[k], m_done);
      else passes++;
      if (rdy_a[k] !== m_idle) $display("FAIL ready u%0d cyc %0d: got %b want %b", k, c, rdy_a[k], m_idle);
      else passes++;
      if (busy_a[k] !== !m_idle) $display("FAIL busy u%0d cyc %0d: got %b want %b", k, c, busy_a[k], !m_idle);
      else passes++;
      if ((abort_t != 0 && t >= abort_t) || (c >= min_c && src.size() == 0 && m_idle)) break;
      if (c > 4000) begin
        total++;
        $display("FAIL timeout u%0d: frame still pending after %0d cycles", k, c);
        break;
      end
    end
    tx_valid = '0;
    baud_tick = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; baud_tick = 1'b0; tx_valid = '0; tx_data = '0;
    #7 reset = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      total += 4;
      if (tx_a[k] !== 1'b1) $display("FAIL rst_tx u%0d: got %b want 1", k, tx_a[k]); else passes++;
      if (rdy_a[k] !== 1'b1) $display("FAIL rst_ready u%0d: got %b want 1", k, rdy_a[k]); else passes++;
      if (busy_a[k] !== 1'b0) $display("FAIL rst_busy u%0d: got %b want 0", k, busy_a[k]); else passes++;
      if (done_a[k] !== 1'b0) $display("FAIL rst_done u%0d: got %b want 0", k, done_a[k]); else passes++;
    end
    @(negedge clk) reset = 1'b0;
    run(0, 64, 0);
  endtask

  task automatic test_8n1();
    src.push_back(8'h55);
    run(0, 0, 0);
  endtask

  task automatic test_parity();
    src.push_back(8'h07); run(2, 0, 0);
    src.push_back(8'h07); run(1, 0, 0);
    src.push_back(8'h00); run(1, 0, 0);
  endtask

  task automatic test_back_to_back();
    src.push_back(8'hA5);
    src.push_back(8'h3C);
    run(0, 0, 0);
  endtask

  task automatic test_stop2_coincident();
    ph = 15;
    src.push_back(8'($urandom));
    run(3, 0, 0);
  endtask

  task automatic test_reset_mid_frame();
    ph = 0;
    src.push_back(8'hF0);
    run(0, 0, 5);
    #3 reset = 1'b1;
    #1;
    total += 3;
    if (tx_a[0] !== 1'b1) $display("FAIL abort_tx: got %b want 1", tx_a[0]); else passes++;
    if (done_a[0] !== 1'b0) $display("FAIL abort_done: got %b want 0", done_a[0]); else passes++;
    if (rdy_a[0] !== 1'b1) $display("FAIL abort_ready: got %b want 1", rdy_a[0]); else passes++;
    @(negedge clk) reset = 1'b0;
    src.push_back(8'hFF);
    run(0, 0, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      ph = $urandom_range(0, 15);
      for (int n = 0; n < 3; n++) src.push_back(8'($urandom));
      run(k, $urandom_range(0, 40), 0);
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_back_to_back();
    test_stop2_coincident();
    test_reset_mid_frame();
    test_random();
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
